uart_tx_fsm: RTL

Frame controller for the UART transmitter. It accepts a parallel word on a `Data_Valid` strobe, latches parity, and sequences the serializer through start bit, data bits, optional parity bit and stop bit. It owns the TX line mux and drives `TX_OUT` and `busy` towards the system controller. It sits between the register/FIFO side of UART_TX and the existing shift serializer, sharing `CLK`/`RST` with it.

---
 rtl/uart_tx_fsm.sv | 119 +++++++++++
 1 files changed

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm -- frame controller for the UART transmitter.
//
// Accepts a word on Data_Valid, latches its parity, and walks the shift
// serializer through START, DATA, optional PARITY and STOP. It owns the TX line
// mux, so TX_OUT and busy are decoded from the registered state only.
//
// Ports:
//   CLK, RST        bit clock; asynchronous active-low reset
//   Data_Valid      upstream word strobe
//   P_DATA          word being loaded (parity only; serializer holds the data)
//   PAR_EN/PAR_TYP  parity enable; 0 = even, 1 = odd
//   ser_done        serializer is presenting its last data bit
//   ser_data        serializer's current data bit
//   ser_en          shift enable to the serializer (DATA only)
//   mux_sel         00 start, 01 stop/idle, 10 data, 11 parity
//   busy            frame in progress
//   TX_OUT          serial line
//
// Build option: define UART_TX_B2B_EN to accept a new word during STOP.
// This gives back-to-back frames, and busy drops in STOP.
module uart_tx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Data_Valid,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic [1:0]            mux_sel,
    output logic                  busy,
    output logic                  TX_OUT
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0] state_q, state_d;
    logic       par_bit_q, par_bit_d;
    logic       par_en_q, par_en_d;
    logic       accept;

    // Next state and frame-configuration capture.
    always_comb begin
        state_d   = state_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        accept    = 1'b0;
        case (state_q)
            S_IDLE:   accept = Data_Valid;
            S_START:  state_d = S_DATA;
            S_DATA:   if (ser_done) state_d = par_en_q ? S_PARITY : S_STOP;
            S_PARITY: state_d = S_STOP;
            S_STOP: begin
                state_d = S_IDLE;
`ifdef UART_TX_B2B_EN
                accept  = Data_Valid;
`endif
            end
            default:  state_d = S_IDLE;   // illegal encodings fall back to idle
        endcase
        // The parity bit and enable are frozen here, so later changes to the
        // configuration inputs cannot disturb the frame in flight.
        if (accept) begin
            state_d   = S_START;
            par_en_d  = PAR_EN;
            par_bit_d = PAR_TYP ? ~^P_DATA : ^P_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
        end
    end

    // Outputs are decoded from the registered state only.
    always_comb begin
        mux_sel = 2'b01;
        ser_en  = 1'b0;
        busy    = 1'b0;
        case (state_q)
            S_START:  begin mux_sel = 2'b00; busy = 1'b1; end
            S_DATA:   begin mux_sel = 2'b10; busy = 1'b1; ser_en = 1'b1; end
            S_PARITY: begin mux_sel = 2'b11; busy = 1'b1; end
            S_STOP: begin
                mux_sel = 2'b01;
`ifdef UART_TX_B2B_EN
                busy    = 1'b0;
`else
                busy    = 1'b1;
`endif
            end
            default:  mux_sel = 2'b01;
        endcase
    end

    always_comb begin
        case (mux_sel)
            2'b00:   TX_OUT = 1'b0;
            2'b10:   TX_OUT = ser_data;
            2'b11:   TX_OUT = par_bit_q;
            default: TX_OUT = 1'b1;
        endcase
    end

endmodule
